// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int SERIAL_ADDSUB_WIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub; ovf exists only with SERIAL_ADDSUB_OVF_EN.
interface serial_addsub_if #(
  parameter int WIDTH = serial_addsub_pkg::SERIAL_ADDSUB_WIDTH_DEF
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
`else
  modport master (output start, sub, a, b, input busy, done, sum, cout);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_addsub_fas.sv
// Single-bit full-adder cell: y1 = sum bit, y2 = carry out.
module fas (
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic y1,
  output logic y2
);

  assign y1 = i1 ^ i2 ^ i3;
  assign y2 = (i1 & i2) | (i3 & (i1 ^ i2));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/sub, LSB first, one fas cell per clock.
// Optional overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDSUB_WIDTH_DEF
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             y1, y2;
  logic             last_bit;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fas u_fas (
    .i1 (a_q[0]),
    .i2 (b_q[0]),
    .i3 (carry_q),
    .y1 (y1),
    .y2 (y2)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // subtraction as a + ~b + 1: invert b and seed the carry with 1
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {y1, res_q[WIDTH-1:1]};
        carry_d = y2;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // publish on the same edge the final bit is produced
          sum_d   = {y1, res_q[WIDTH-1:1]};
          cout_d  = y2;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = carry_q ^ y2;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: arithmetic reference model plus cycle-accurate handshake expectations.
module tb_serial_addsub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           next_free = 0;
  int           act_c   = 0;
  bit           act_v   = 1'b0;
  bit           chk_en  = 1'b0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;

  // Plain integer arithmetic: signed/unsigned views of the operands.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input bit s);
    exp_t        e;
    int unsigned m;
    int unsigned r;
    int          sa, sb, sr;
    m  = 32'd1 << W;
    sa = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
    sb = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
    if (s) begin
      r      = (a + m - b) % m;
      e.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      r      = (a + b) % m;
      e.cout = ((a + b) >= m);
      sr     = sa + sb;
    end
    e.sum = r[W-1:0];
    e.ovf = (sr < -int'(m / 2)) || (sr >= int'(m / 2));
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Reference: block accepts a start only once W+2 cycles have passed since the last accept.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      act_v     = 1'b0;
      last_sum  = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
      next_free = cyc + 1;
      chk_en    = 1'b1;
    end else if (bus.start === 1'b1 && cyc >= next_free) begin
      q.push_back(model(bus.a, bus.b, bus.sub));
      act_c     = cyc;
      act_v     = 1'b1;
      next_free = cyc + W + 2;
    end
  end

  // Monitor: compares handshake and held result every cycle, pops on done.
  initial forever begin
    bit   exp_busy, exp_done;
    exp_t e;
    @(negedge clk);
    if (chk_en) begin
      exp_busy = act_v && (cyc >= act_c) && (cyc - act_c < W);
      exp_done = act_v && (cyc == act_c + W);
      if (exp_done) begin
        if (q.size() == 0) begin
          chk("queue_nonempty", 32'd0, 32'd1);
        end else begin
          e         = q.pop_front();
          last_sum  = e.sum;
          last_cout = e.cout;
          last_ovf  = e.ovf;
        end
      end
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("sum",  32'(bus.sum),  32'(last_sum));
      chk("cout", 32'(bus.cout), 32'(last_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
      chk("ovf",  32'(bus.ovf),  32'(last_ovf));
`endif
    end
  end

  task automatic drive(input int unsigned a, input int unsigned b, input bit s);
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.sub   = s;
    bus.start = 1'b1;
  endtask

  task automatic op(input int unsigned a, input int unsigned b, input bit s);
    @(negedge clk);
    drive(a, b, s);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 1) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    op(23, 42, 0);
    op(255, 1, 0);
    op(127, 1, 0);
    op(100, 30, 1);
    op(30, 100, 1);

    // starts during busy and done are dropped; first idle start is taken
    @(negedge clk);
    drive(77, 11, 0);
    repeat (W + 1) begin
      @(negedge clk);
      drive($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    drive(9, 4, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // reset in the 4th shift cycle
    @(negedge clk);
    drive(200, 55, 0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op(5, 3, 0);

    // start held high: one completion every W+2 cycles
    @(negedge clk);
    repeat (50) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // random operations with random gaps
    repeat (30) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      @(negedge clk);
      bus.start = 1'b0;
      repeat ($urandom_range(0, W + 3)) @(negedge clk);
    end
    repeat (W + 3) @(negedge clk);

    chk("drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial WIDTH-bit adder/subtractor built around the team's single-bit full-adder cell `fas`. It processes one bit per clock, LSB first, and keeps the carry in a register between bits. It sits directly downstream of `fas`: it consumes the cell's sum and carry outputs each cycle and wraps them in a start/busy/done handshake. The result is a registered word plus carry-out.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥ 2).
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request; sampled only in IDLE.
- `sub` input, 1 bit: 0 = a + b, 1 = a − b. Sampled with `start`.
- `a` input, WIDTH bits: operand A, sampled with `start`.
- `b` input, WIDTH bits: operand B, sampled with `start`.
- `busy` output, 1 bit: high while bits are being processed.
- `done` output, 1 bit: single-cycle pulse when `sum`/`cout` update.
- `sum` output, WIDTH bits: registered result, held until the next completion.
- `cout` output, 1 bit: final carry. With `sub`=1, 1 = no borrow.
- `ovf` output, 1 bit: two's-complement overflow. Present only with `SERIAL_ADDSUB_OVF_EN`.

## Operation
- State machine:
  - IDLE: on `start`=1, load `a` into shift register A, and `b` XOR {WIDTH{`sub`}} into shift register B. Carry register ← `sub`, bit counter ← 0. Go to SHIFT.
  - SHIFT: drive `fas` with `i1`=A[0], `i2`=B[0], `i3`=carry. Shift A and B right by one. Shift `y1` into the MSB of the internal result register. Carry ← `y2`, counter ← counter + 1. When counter = WIDTH−1, go to DONE.
  - DONE: `done`=1. `sum` ← internal result and `cout` ← carry, both in the same edge as entry. Then go to IDLE.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- `start` in SHIFT or DONE is ignored, with no queuing. A new operation can begin no sooner than the first IDLE cycle.
- `sum`, `cout` and `ovf` change only on entry to DONE. Internal shifting is never visible on the outputs.
- `busy` = (state == SHIFT). `done` = (state == DONE).
- Reset, including in the middle of an operation: state ← IDLE. `busy`, `done`, `sum`, `cout` and `ovf` ← 0. Shift registers, carry and counter ← 0. The partial result is discarded.

## Timing
- Edge E0 samples `start`=1. `busy`=1 in the cycles after E0 through E_WIDTH (WIDTH cycles).
- After E_WIDTH: `busy`=0, `done`=1, and the new `sum`/`cout` are visible.
- After E_(WIDTH+1): `done`=0 and the block is in IDLE. A `start` sampled at E_(WIDTH+2) is accepted.
- Latency from the `start` edge to the `done` cycle is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- `rst` takes priority over `start` at the same edge.

## Configuration
- `SERIAL_ADDSUB_OVF_EN` defined:
  - Add port `ovf` and a 1-bit register that captures the carry into the MSB during the last SHIFT cycle.
  - On entry to DONE, `ovf` ← (captured MSB carry-in) XOR (final carry). Reset value is 0.
- `SERIAL_ADDSUB_OVF_EN` undefined: no `ovf` port and no extra registers. All other behaviour is identical.

## Structure
- Package `serial_addsub_pkg`:
  - state typedef: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - constant `SERIAL_ADDSUB_WIDTH_DEF` = 8.
- One sub-module: instantiate the existing `fas` cell once as the per-bit datapath (`y1` = sum bit, `y2` = carry out).
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- WIDTH=8, a=23, b=42, `sub`=0, single `start` pulse -> `busy` high 8 cycles, `done` on the 9th cycle after the start edge, `sum`=65, `cout`=0.
- a=255, b=1, `sub`=0 -> `sum`=0, `cout`=1, `ovf`=0. Also a=127, b=1 -> `sum`=128, `cout`=0, `ovf`=1 (macro on).
- a=100, b=30, `sub`=1 -> `sum`=70, `cout`=1. Then a=30, b=100, `sub`=1 -> `sum`=186 (8'hBA), `cout`=0.
- `start` pulsed with new operands in every `busy` cycle and in the `done` cycle -> all ignored. The result equals the first operation's result, and the next accepted start is the first IDLE cycle.
- a=200, b=55; assert `rst` at the 4th SHIFT cycle -> the next cycle has `busy`=0, `done`=0, `sum`=0, `cout`=0, and `done` never fires. A subsequent start with a=5, b=3 gives `sum`=8.
- Back-to-back operations, with `start` held high continuously -> one completion every 10 cycles (WIDTH=8). Each `sum` matches its own operands, and `sum` is held stable between `done` pulses.
